// File: rtl/barret_2089_pkg.sv
// Shared constants and types for the q = 2089 Barrett reducer.
package barret_2089_pkg;

  localparam int unsigned Q     = 2089;
  localparam int unsigned K     = 12;
  localparam int unsigned MU    = 8031;  // floor(2^24 / Q)
  localparam int unsigned IN_W  = 23;
  localparam int unsigned OUT_W = 12;

  typedef logic [OUT_W-1:0] coef_t;
  typedef logic [IN_W-1:0]  wide_t;

endpackage

// File: rtl/barret_cond_sub.sv
// Conditional subtract of Q: r_o = (r_i >= Q) ? r_i - Q : r_i, truncated to OW bits.
module barret_cond_sub
  import barret_2089_pkg::*;
#(
  parameter int unsigned OW = 14
) (
  input  logic [13:0]   r_i,
  output logic [OW-1:0] r_o
);

  logic [13:0] diff;

  always_comb begin
    diff = r_i;
    if (r_i >= 14'(Q)) diff = r_i - 14'(Q);
    r_o = OW'(diff);
  end

endmodule

// File: rtl/barret_for_2089.sv
// Registered Barrett reducer: dout_r = din_a mod 2089.
// Define BARRET_FOR_2089_PIPE_EN for a 2-stage version (register after the multiplier).
module barret_for_2089
  import barret_2089_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  wide_t din_a,
  output coef_t dout_r
);

  logic [11:0] t;
  logic [11:0] qh;
  logic [11:0] qh_s;
  logic [13:0] x_lo;
  logic [13:0] r0;
  logic [13:0] r1;
  coef_t       dout_d;

  always_comb begin
    t  = din_a[22:11];
    qh = 12'((25'(t) * 25'(MU)) >> 13);
  end

`ifdef BARRET_FOR_2089_PIPE_EN
  // Only the low 14 bits of x matter: r0 is exact modulo 2^14 and known to be < 3Q.
  logic [13:0] x_lo_q;
  logic [11:0] qh_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      x_lo_q <= '0;
      qh_q   <= '0;
    end else begin
      x_lo_q <= din_a[13:0];
      qh_q   <= qh;
    end
  end

  always_comb begin
    x_lo = x_lo_q;
    qh_s = qh_q;
  end
`else
  always_comb begin
    x_lo = din_a[13:0];
    qh_s = qh;
  end
`endif

  always_comb r0 = x_lo - 14'(qh_s) * 14'(Q);

  barret_cond_sub #(.OW(14)) u_sub0 (
    .r_i (r0),
    .r_o (r1)
  );

  barret_cond_sub #(.OW(OUT_W)) u_sub1 (
    .r_i (r1),
    .r_o (dout_d)
  );

  always_ff @(posedge clk) begin
    if (rst) dout_r <= '0;
    else     dout_r <= dout_d;
  end

endmodule

// File: tb/tb_barret_for_2089.sv
// Scoreboard bench for barret_for_2089; honours BARRET_FOR_2089_PIPE_EN for latency.
module tb_barret_for_2089;
  import barret_2089_pkg::*;

`ifdef BARRET_FOR_2089_PIPE_EN
  localparam int unsigned LAT = 2;
`else
  localparam int unsigned LAT = 1;
`endif

  logic  clk = 1'b0;
  logic  rst;
  wide_t din_a;
  coef_t dout_r;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  typedef struct {
    coef_t exp;
    string tag;
  } sb_t;
  sb_t sb[$];

  barret_for_2089 dut (
    .clk    (clk),
    .rst    (rst),
    .din_a  (din_a),
    .dout_r (dout_r)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input coef_t got, input coef_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: dout_r=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic coef_t ref_mod(input wide_t x);
    int unsigned v;
    v = int'(x);
    return coef_t'(v % 2089);
  endfunction

  // One cycle: compare the oldest due entry, then drive the next operand on the falling edge.
  task automatic step(input logic r, input wide_t x, input string tag);
    sb_t e;
    @(negedge clk);
    if (sb.size() >= LAT) begin
      e = sb.pop_front();
      check(e.tag, dout_r, e.exp);
    end
    rst   = r;
    din_a = x;
    if (r) foreach (sb[i]) sb[i].exp = '0;
    e.exp = r ? coef_t'(0) : ref_mod(x);
    e.tag = $sformatf("%s x=%0d rst=%0b", tag, x, r);
    sb.push_back(e);
  endtask

  initial begin
    wide_t b2b [4];
    wide_t bnd [5];
    b2b = '{23'd2088, 23'd2089, 23'd0, 23'd8388607};
    bnd = '{23'd2089, 23'd2090, 23'd4178, 23'd4363920, 23'd8388607};
    rst   = 1'b1;
    din_a = 23'd5000;

    step(1'b1, 23'd5000, "reset");
    step(1'b1, 23'd5000, "reset");
    step(1'b0, 23'd5000, "release");

    for (int unsigned i = 0; i < 2089; i++) step(1'b0, wide_t'(i), "sweep");

    foreach (bnd[i]) step(1'b0, bnd[i], "boundary");

    for (int unsigned k = 0; k < 3; k++)
      foreach (b2b[i]) step(1'b0, b2b[i], "b2b");

    for (int unsigned i = 0; i < 20000; i++) step(1'b0, wide_t'($urandom()), "random");

    for (int unsigned i = 0; i < 40; i++)
      step(i == 20, wide_t'(3000 + i * 97), "midreset");

    for (int unsigned i = 0; i < LAT; i++) step(1'b0, 23'd0, "flush");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
